// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate-multiplier family: default operand
// widths and the divider FSM state encoding.
package approx_mul_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder; keep the difference only when it does not borrow.
module div_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   carry;
  logic [W-1:0] diff;

  // rem - dvs as rem + ~dvs + 1; final carry-out high means no borrow
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a  (rem_i[i]),
      .b  (~dvs_i[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  assign q_o   = carry[W];
  assign rem_o = q_o ? diff : rem_i;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the ripple building block of the multiplier family.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/approx_mul_inverse_div.sv
// Sequential restoring divider recovering operand a from product Y and known b,
// one quotient bit per cycle, MSB first, with valid/ready handshakes.
import approx_mul_pkg::*;

module approx_mul_inverse_div #(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  div_state_e             state_q;
  logic [DIVIDEND_W-1:0]  dvd_q;
  logic [DIVISOR_W-1:0]   dvs_q;
  logic [DIVISOR_W:0]     rem_q;
  logic [DIVIDEND_W-1:0]  quo_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   div_zero_q;

  logic [DIVISOR_W:0]     rem_shl;
  logic [DIVISOR_W:0]     rem_d;
  logic                   qbit_d;

  // shift the next dividend MSB into the partial remainder
  assign rem_shl = (rem_q << 1) | {{DIVISOR_W{1'b0}}, dvd_q[DIVIDEND_W-1]};

  div_step #(.W(DIVISOR_W + 1)) u_step (
    .rem_i (rem_shl),
    .dvs_i ({1'b0, dvs_q}),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dvd_q <= dividend;
          dvs_q <= divisor;
          cnt_q <= '0;
          if (divisor == '0) begin
            state_q    <= DONE;
            quo_q      <= '1;
            rem_q      <= {1'b0, dividend[DIVISOR_W-1:0]};
            div_zero_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            quo_q      <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
          end
        end
        RUN: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_d;
          quo_q <= (quo_q << 1) | {{(DIVIDEND_W-1){1'b0}}, qbit_d};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q[DIVISOR_W-1:0];
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_approx_mul_inverse_div.sv
// Directed bench for the restoring divider: latency, zero divisor, backpressure,
// ignored mid-run requests, reset abort and a full 8-bit by 4-bit sweep.
module tb_approx_mul_inverse_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid, out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  approx_mul_inverse_div #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic [7:0] a, input logic [3:0] b);
    in_valid = 1'b1; dividend = a; divisor = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nvec++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_hold: rdy=%0b vld=%0b q=%0d r=%0d dz=%0b, want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    rst_n = 1'b1;
    step();
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL reset_release: rdy=%0b vld=%0b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    start(8'd200, 4'd7);
    wait_done(cyc);
    nvec++;
    if (cyc !== 8) begin
      nerr++;
      $display("FAIL latency_200_7: got %0d cycles, want 8", cyc);
    end
    nvec++;
    if ({quotient, remainder, div_zero} !== {8'd28, 4'd4, 1'b0}) begin
      nerr++;
      $display("FAIL div_200_7: got q=%0d r=%0d dz=%0b, want 28 4 0", quotient, remainder, div_zero);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int cyc;
    start(8'd255, 4'd1);
    wait_done(cyc);
    nvec++;
    if ({quotient, remainder, div_zero} !== {8'd255, 4'd0, 1'b0}) begin
      nerr++;
      $display("FAIL div_255_1: got q=%0d r=%0d dz=%0b, want 255 0 0", quotient, remainder, div_zero);
    end
    release_result();
    start(8'd15, 4'd15);
    wait_done(cyc);
    nvec++;
    if ({quotient, remainder, div_zero} !== {8'd1, 4'd0, 1'b0}) begin
      nerr++;
      $display("FAIL div_15_15: got q=%0d r=%0d dz=%0b, want 1 0 0", quotient, remainder, div_zero);
    end
    release_result();
  endtask

  task automatic test_div_zero();
    int cyc;
    start(8'd9, 4'd0);
    wait_done(cyc);
    // zero divisor skips RUN: result is visible in the cycle after acceptance
    nvec++;
    if (cyc !== 0) begin
      nerr++;
      $display("FAIL latency_div0: got %0d extra cycles, want 0", cyc);
    end
    nvec++;
    if ({quotient, remainder, div_zero} !== {8'd255, 4'd9, 1'b1}) begin
      nerr++;
      $display("FAIL div_9_0: got q=%0d r=%0d dz=%0b, want 255 9 1", quotient, remainder, div_zero);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad = 0;
    start(8'd200, 4'd7);
    wait_done(cyc);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; dividend = 8'd50; divisor = 4'd3;
      step();
      if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd28, 4'd4, 1'b0}) bad++;
    end
    in_valid = 1'b0;
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL hold_done: %0d of 20 cycles changed, want 0", bad);
    end
    release_result();
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL release_idle: rdy=%0b vld=%0b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_in_run();
    int cyc;
    start(8'd200, 4'd7);
    for (int i = 0; i < 4; i++) begin
      in_valid = ~i[0]; dividend = 8'd50; divisor = 4'd3;
      step();
    end
    in_valid = 1'b0;
    wait_done(cyc);
    nvec++;
    if ({quotient, remainder, div_zero, cyc} !== {8'd28, 4'd4, 1'b0, 32'd4}) begin
      nerr++;
      $display("FAIL ignore_run: got q=%0d r=%0d dz=%0b tail=%0d, want 28 4 0 4",
               quotient, remainder, div_zero, cyc);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start(8'd200, 4'd7);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, in_ready, quotient} !== {1'b0, 1'b1, 8'd0}) begin
      nerr++;
      $display("FAIL reset_abort: vld=%0b rdy=%0b q=%0d, want 0 1 0", out_valid, in_ready, quotient);
    end
    step();
    rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ready_after_reset: got %0b, want 1", in_ready);
    end
    start(8'd100, 4'd3);
    wait_done(cyc);
    nvec++;
    if ({quotient, remainder, div_zero, cyc} !== {8'd33, 4'd1, 1'b0, 32'd8}) begin
      nerr++;
      $display("FAIL div_100_3: got q=%0d r=%0d dz=%0b lat=%0d, want 33 1 0 8",
               quotient, remainder, div_zero, cyc);
    end
    release_result();
  endtask

  task automatic test_sweep();
    int cyc;
    int shown = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start(a[7:0], b[3:0]);
        wait_done(cyc);
        nvec++;
        if (cyc != 8 || div_zero !== 1'b0 || int'(remainder) >= b ||
            int'(quotient) * b + int'(remainder) != a) begin
          nerr++;
          if (shown < 10)
            $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%0b lat=%0d, want q*b+r=a r<b dz=0 lat=8",
                     a, b, quotient, remainder, div_zero, cyc);
          shown++;
        end
        release_result();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) step();
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/approx_mul_inverse_div.md
APPROX_MUL_INVERSE_DIV -- requirements
Module: approx_mul_inverse_div

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, dividend/quotient width (2x operand width of the 4x4 multiplier family).
REQ-002 SHALL have parameter DIVISOR_W, default 4, divisor/remainder width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operands present.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port dividend, input, DIVIDEND_W, product-domain value Y.
REQ-008 SHALL have port divisor, input, DIVISOR_W, known operand b.
REQ-009 SHALL have port out_valid, output, 1, result held stable.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result.
REQ-011 SHALL have port quotient, output, DIVIDEND_W, recovered operand a.
REQ-012 SHALL have port remainder, output, DIVISOR_W, Y mod b.
REQ-013 SHALL have port div_zero, output, 1, divisor was zero.

Function
REQ-014 SHALL implement exact unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-015 SHALL use FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept operands on the edge where in_valid & in_ready; capture dividend and divisor into internal registers; ignore input ports afterwards.
REQ-017 SHALL, on acceptance with divisor!=0, go IDLE->RUN, clear partial remainder (DIVISOR_W+1 bits) and step counter.
REQ-018 SHALL, each RUN cycle: shift remainder left inserting next dividend MSB; if remainder >= divisor, subtract and set quotient bit 1, else keep and set 0.
REQ-019 SHALL perform exactly DIVIDEND_W RUN cycles; counter terminal count DIVIDEND_W-1 triggers RUN->DONE.
REQ-020 SHALL give latency: acceptance edge E0, out_valid high after edge E(DIVIDEND_W) (E8 by default).
REQ-021 SHALL, on acceptance with divisor==0, go IDLE->DONE directly, out_valid high after E1's preceding edge E0+1, quotient all-ones, remainder = dividend[DIVISOR_W-1:0], div_zero=1.
REQ-022 SHALL hold quotient, remainder, div_zero, out_valid stable in DONE until out_ready=1 (backpressure unlimited).
REQ-023 SHALL go DONE->IDLE on edge with out_ready=1; no same-cycle re-accept (in_ready low in DONE).
REQ-024 SHALL ignore in_valid in RUN and DONE; no queuing.
REQ-025 SHALL guarantee remainder < divisor and quotient*divisor+remainder == dividend for divisor!=0.
REQ-026 SHALL keep div_zero=0 for any non-zero divisor result.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-RUN, asynchronously enter IDLE, abort the operation, discard captured operands.
REQ-028 SHALL reset outputs: in_ready=1 after reset release, out_valid=0, quotient=0, remainder=0, div_zero=0.
REQ-029 SHALL accept new operands on the first edge after rst_n deasserts.

Structure
REQ-030 SHALL place FSM state enum and default widths in shared package approx_mul_pkg.
REQ-031 SHALL instantiate one sub-module div_step: combinational (DIVISOR_W+1)-bit compare/subtract built from existing full_adder cells, outputs next remainder and quotient bit.
REQ-032 SHALL contain no latches; all sequential state in one clocked process with async reset.

Verification
REQ-033 SHALL test 200/7 -> quotient 28, remainder 4, div_zero 0, out_valid 8 cycles after accept.
REQ-034 SHALL test 255/1 and 15/15 -> (255,0) and (1,0); plus exhaustive 256x15 sweep vs golden a*b+r check.
REQ-035 SHALL test 9/0 -> quotient 255, remainder 9, div_zero 1, out_valid after 1 cycle.
REQ-036 SHALL test out_ready low 20 cycles in DONE -> outputs unchanged, in_ready 0, then IDLE on release.
REQ-037 SHALL test in_valid pulsed with different operands during RUN -> result equals first accepted operands.
REQ-038 SHALL test rst_n asserted at RUN cycle 4 -> immediate out_valid 0, in_ready 1 after release, next divide 100/3 -> (33,1).
